// File: rtl/mux_16to1.sv
// rtl/mux_16to1.sv - registered 16-to-1 single-bit mux built from a tree of 2-to-1 cells
// Cell and tree kept as one file; the tree is combinational and feeds a single output flop.

module mux_16to1_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_s,
   output logic o_y
);

   // A known select passes only the chosen operand, so X on the other input stays out.
   assign o_y = i_s ? i_b : i_a;

endmodule

module mux_16to1 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] din,
   input  logic [3:0]  sel,
   output logic        f
);

   logic [7:0] w_l0;
   logic [3:0] w_l1;
   logic [1:0] w_l2;
   logic       w_mux_d;
   logic       r_f;

   genvar k;
   generate
      for (k = 0; k < 8; k++) begin : g_l0
         mux_16to1_cell u_cell (
            .i_a (din[2*k]),
            .i_b (din[2*k+1]),
            .i_s (sel[0]),
            .o_y (w_l0[k])
         );
      end
      for (k = 0; k < 4; k++) begin : g_l1
         mux_16to1_cell u_cell (
            .i_a (w_l0[2*k]),
            .i_b (w_l0[2*k+1]),
            .i_s (sel[1]),
            .o_y (w_l1[k])
         );
      end
      for (k = 0; k < 2; k++) begin : g_l2
         mux_16to1_cell u_cell (
            .i_a (w_l1[2*k]),
            .i_b (w_l1[2*k+1]),
            .i_s (sel[2]),
            .o_y (w_l2[k])
         );
      end
   endgenerate

   mux_16to1_cell u_l3 (
      .i_a (w_l2[0]),
      .i_b (w_l2[1]),
      .i_s (sel[3]),
      .o_y (w_mux_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_f <= 1'b0;
      end else begin
         r_f <= w_mux_d;
      end
   end

   assign f = r_f;

endmodule

// File: tb/tb_mux_16to1.sv
// tb/tb_mux_16to1.sv - directed and randomized checks of mux_16to1 against a reference model

module tb_mux_16to1;

   logic        clk;
   logic        rst_n;
   logic [15:0] din;
   logic [3:0]  sel;
   logic        f;

   int n_checks;
   int n_fail;

   mux_16to1 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din),
      .sel   (sel),
      .f     (f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Sample one time unit after the rising edge, away from the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: the selected bit of the data word, by plain shift-and-mask.
   function automatic logic ref_bit(input logic [15:0] word, input int idx);
      return logic'((word >> idx) & 16'h1);
   endfunction

   logic [15:0] sweep_din;
   logic [3:0]  sweep_sel [4];
   logic        sweep_exp [4];
   logic [15:0] known;
   logic [15:0] drive;
   logic        exp_f;
   int          s;

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // Reset held with all-ones data: f must stay low across edges.
      rst_n = 1'b0;
      din   = 16'hFFFF;
      sel   = 4'h5;
      #1;
      check("reset_initial", f, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_hold", f, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset_release_no_edge", f, 1'b0);
      tick();
      check("reset_first_edge", f, 1'b1);

      // Directed sweep, also confirming f waits for the edge after each sel change.
      sweep_din    = 16'h3f0a;
      sweep_sel[0] = 4'h0; sweep_exp[0] = 1'b0;
      sweep_sel[1] = 4'h1; sweep_exp[1] = 1'b1;
      sweep_sel[2] = 4'h6; sweep_exp[2] = 1'b0;
      sweep_sel[3] = 4'hc; sweep_exp[3] = 1'b1;
      din = sweep_din;
      sel = 4'h5;
      tick();
      exp_f = 1'b0;
      check("sweep_setup", f, exp_f);
      for (int i = 0; i < 4; i++) begin
         sel = sweep_sel[i];
         #2;
         check("sweep_hold_before_edge", f, exp_f);
         tick();
         check("sweep_after_edge", f, sweep_exp[i]);
         exp_f = sweep_exp[i];
      end

      // Walking one: selected bit then its neighbour.
      for (int i = 0; i < 16; i++) begin
         din = 16'h1 << i;
         sel = 4'(i);
         tick();
         check("walk1_hit", f, 1'b1);
         sel = 4'((i + 1) % 16);
         tick();
         check("walk1_neighbour", f, 1'b0);
      end

      // Walking zero: only the cleared bit reads 0.
      for (int i = 0; i < 16; i++) begin
         din = ~(16'h1 << i);
         for (int j = 0; j < 16; j++) begin
            sel = 4'(j);
            tick();
            check("walk0", f, (j == i) ? 1'b0 : 1'b1);
         end
      end

      // Asynchronous reset pulse between edges.
      din = 16'h8000;
      sel = 4'hf;
      tick();
      check("async_pre", f, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_asserted_no_edge", f, 1'b0);
      #1;
      rst_n = 1'b1;
      #1;
      check("async_released_no_edge", f, 1'b0);
      tick();
      check("async_next_edge", f, 1'b1);

      // Randomized: X on unselected bits, reference f(N+1) = din(N)[sel(N)].
      for (int n = 0; n < 1000; n++) begin
         known = 16'($urandom);
         s     = int'($urandom_range(0, 15));
         drive = known;
         if ($urandom_range(0, 3) == 0) begin
            for (int b = 0; b < 16; b++) begin
               if (b != s && $urandom_range(0, 1) == 1) drive[b] = 1'bx;
            end
         end
         din   = drive;
         sel   = 4'(s);
         exp_f = ref_bit(known, s);
         tick();
         check("random_value", f, exp_f);
         check("random_not_x", $isunknown(f) ? 1'b1 : 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
